// File: rtl/position_sequencer_if.sv
// Command and stepper-handshake bundle for position_sequencer.
// The master side issues absolute targets and reports stepper completion;
// the slave side (the sequencer) accepts commands and drives step segments.
interface position_sequencer_if #(
    parameter int POS_BITS   = 16,
    parameter int COUNT_BITS = 8
);
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic signed [POS_BITS-1:0]   target_x;
    logic signed [POS_BITS-1:0]   target_y;
    logic                         trigger;
    logic signed [COUNT_BITS-1:0] num_steps_x;
    logic signed [COUNT_BITS-1:0] num_steps_y;
    logic                         stepper_done;

    modport master (
        output cmd_valid, target_x, target_y, stepper_done,
        input  cmd_ready, trigger, num_steps_x, num_steps_y
    );

    modport slave (
        input  cmd_valid, target_x, target_y, stepper_done,
        output cmd_ready, trigger, num_steps_x, num_steps_y
    );
endinterface

// File: rtl/position_sequencer.sv
// position_sequencer: breaks absolute XY targets into clamped relative step
// segments for a downstream XY stepper controller and tracks the committed
// position. Optional origin-reset feature: define POSITION_SEQUENCER_HOME_EN.
module position_sequencer #(
    parameter int POS_BITS      = 16,
    parameter int COUNT_BITS    = 8,
    parameter int START_TIMEOUT = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clk_en,
    position_sequencer_if.slave        bus,
    input  logic                       home,
    output logic signed [POS_BITS-1:0] pos_x,
    output logic signed [POS_BITS-1:0] pos_y,
    output logic                       busy
);

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        TRIG,
        WAIT_START,
        WAIT_DONE
    } state_t;

    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(START_TIMEOUT - 1);
    localparam logic signed [POS_BITS:0] MAX_D = (POS_BITS + 1)'((1 << (COUNT_BITS - 1)) - 1);
    localparam logic signed [POS_BITS:0] MIN_D = -MAX_D;

    state_t                       state;
    state_t                       state_next;
    logic signed [POS_BITS-1:0]   tgt_x;
    logic signed [POS_BITS-1:0]   tgt_y;
    logic signed [POS_BITS:0]     delta_x;
    logic signed [POS_BITS:0]     delta_y;
    logic signed [COUNT_BITS-1:0] seg_x;
    logic signed [COUNT_BITS-1:0] seg_y;
    logic signed [COUNT_BITS-1:0] steps_x;
    logic signed [COUNT_BITS-1:0] steps_y;
    logic [TW-1:0]                wait_cnt;
    logic                         home_req;
    logic                         handshake;
    logic                         commit;

    // Symmetric clamp: the most negative count code is never issued.
    function automatic logic signed [COUNT_BITS-1:0] clamp_step(input logic signed [POS_BITS:0] d);
        if (d > MAX_D)
            clamp_step = MAX_D[COUNT_BITS-1:0];
        else if (d < MIN_D)
            clamp_step = MIN_D[COUNT_BITS-1:0];
        else
            clamp_step = d[COUNT_BITS-1:0];
    endfunction

`ifdef POSITION_SEQUENCER_HOME_EN
    assign home_req = home & clk_en & (state == IDLE);
`else
    logic unused_home;
    assign unused_home = home;
    assign home_req    = 1'b0;
`endif

    // One extra bit so the difference of two extreme positions cannot wrap.
    assign delta_x = {tgt_x[POS_BITS-1], tgt_x} - {pos_x[POS_BITS-1], pos_x};
    assign delta_y = {tgt_y[POS_BITS-1], tgt_y} - {pos_y[POS_BITS-1], pos_y};
    assign seg_x   = clamp_step(delta_x);
    assign seg_y   = clamp_step(delta_y);

    assign handshake = bus.cmd_valid & clk_en & (state == IDLE) & ~home_req;
    assign commit    = clk_en & bus.stepper_done &
                       ((state == WAIT_DONE) | ((state == WAIT_START) & (wait_cnt == TO_LAST)));

    assign bus.cmd_ready   = (state == IDLE) & ~home_req;
    assign bus.trigger     = (state == TRIG);
    assign bus.num_steps_x = steps_x;
    assign bus.num_steps_y = steps_y;
    assign busy            = (state != IDLE);

    // State register; reset aborts any command in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic, advancing only on enabled ticks.
    always_comb begin
        state_next = state;
        if (clk_en) begin
            case (state)
                IDLE:       if (handshake) state_next = CALC;
                CALC:       state_next = ((delta_x == '0) && (delta_y == '0)) ? IDLE : TRIG;
                TRIG:       state_next = WAIT_START;
                WAIT_START: begin
                    if (!bus.stepper_done)
                        state_next = WAIT_DONE;
                    else if (commit)
                        state_next = CALC;
                end
                WAIT_DONE:  if (commit) state_next = CALC;
                default:    state_next = IDLE;
            endcase
        end
    end

    // Target latch, segment registers, start-timeout counter and position commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tgt_x    <= '0;
            tgt_y    <= '0;
            steps_x  <= '0;
            steps_y  <= '0;
            pos_x    <= '0;
            pos_y    <= '0;
            wait_cnt <= '0;
        end else if (clk_en) begin
            if (handshake) begin
                tgt_x <= bus.target_x;
                tgt_y <= bus.target_y;
            end
            if (state == CALC) begin
                steps_x <= seg_x;
                steps_y <= seg_y;
            end
            if (state == TRIG)
                wait_cnt <= '0;
            else if ((state == WAIT_START) && (wait_cnt != TO_LAST))
                wait_cnt <= wait_cnt + TW'(1);
            if (home_req) begin
                pos_x <= '0;
                pos_y <= '0;
            end else if (commit) begin
                pos_x <= pos_x + {{(POS_BITS-COUNT_BITS){steps_x[COUNT_BITS-1]}}, steps_x};
                pos_y <= pos_y + {{(POS_BITS-COUNT_BITS){steps_y[COUNT_BITS-1]}}, steps_y};
            end
        end
    end

endmodule
